// File: rtl/layer2_backprop_pkg.sv
// Shared fixed-point constants, default weight table and state encoding for the
// layer-2 forward/backward blocks.
package layer2_backprop_pkg;

  localparam int INTEGRAL_WIDTH = 4;
  localparam int FRACTION_WIDTH = 16;
  localparam int DW             = INTEGRAL_WIDTH + FRACTION_WIDTH;
  localparam int PROD_W         = 2 * DW;
  localparam int ACC_W          = PROD_W + 2;
  localparam int NUM_IN         = 5;
  localparam int NUM_NODE       = 3;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Saturation bounds expressed at accumulator width, after the fraction shift.
  localparam logic signed [ACC_W-1:0] ACC_SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // W_<node>_<input>: one table used by both the forward and backward layers.
  localparam logic [DW-1:0] W_1_1 = 20'h04CCC;
  localparam logic [DW-1:0] W_1_2 = 20'hFCCCD;
  localparam logic [DW-1:0] W_1_3 = 20'h08000;
  localparam logic [DW-1:0] W_1_4 = 20'hF6667;
  localparam logic [DW-1:0] W_1_5 = 20'h06666;
  localparam logic [DW-1:0] W_2_1 = 20'hF4CCD;
  localparam logic [DW-1:0] W_2_2 = 20'h09999;
  localparam logic [DW-1:0] W_2_3 = 20'hFE667;
  localparam logic [DW-1:0] W_2_4 = 20'h03333;
  localparam logic [DW-1:0] W_2_5 = 20'hF3334;
  localparam logic [DW-1:0] W_3_1 = 20'h06666;
  localparam logic [DW-1:0] W_3_2 = 20'hF8000;
  localparam logic [DW-1:0] W_3_3 = 20'h0CCCC;
  localparam logic [DW-1:0] W_3_4 = 20'hF199A;
  localparam logic [DW-1:0] W_3_5 = 20'h0B333;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Drop the fraction bits (floor) and clamp into the Q4.16 range.
  function automatic logic [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> FRACTION_WIDTH;
    if (s > ACC_SAT_HI)
      return SAT_MAX;
    else if (s < ACC_SAT_LO)
      return SAT_MIN;
    else
      return s[DW-1:0];
  endfunction

endpackage

// File: rtl/fxp_mul_acc_sat.sv
// Signed fixed-point multiply-accumulate with a floor-shift/saturate output stage.
// sum_sat always reflects the running sum including the current product.
module fxp_mul_acc_sat
  import layer2_backprop_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] sum_sat
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_next;

  assign prod     = a * b;
  assign acc_next = acc_reg + ACC_W'(prod);
  assign sum_sat  = sat_shift(acc_next);

  // The final product of a dot product clears the sum so the next one starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_reg <= '0;
    else if (en)
      acc_reg <= last ? '0 : acc_next;
  end

endmodule

// File: rtl/layer2_backprop.sv
// Backward pass of the 5-input/3-node layer: grad_i = sum_j W[j][i]*delta_j,
// computed on one shared MAC over 15 cycles with valid/ready on both sides.
module layer2_backprop
  import layer2_backprop_pkg::*;
#(
  parameter logic [DW-1:0] WEIGHT_1_1 = W_1_1,
  parameter logic [DW-1:0] WEIGHT_1_2 = W_1_2,
  parameter logic [DW-1:0] WEIGHT_1_3 = W_1_3,
  parameter logic [DW-1:0] WEIGHT_1_4 = W_1_4,
  parameter logic [DW-1:0] WEIGHT_1_5 = W_1_5,
  parameter logic [DW-1:0] WEIGHT_2_1 = W_2_1,
  parameter logic [DW-1:0] WEIGHT_2_2 = W_2_2,
  parameter logic [DW-1:0] WEIGHT_2_3 = W_2_3,
  parameter logic [DW-1:0] WEIGHT_2_4 = W_2_4,
  parameter logic [DW-1:0] WEIGHT_2_5 = W_2_5,
  parameter logic [DW-1:0] WEIGHT_3_1 = W_3_1,
  parameter logic [DW-1:0] WEIGHT_3_2 = W_3_2,
  parameter logic [DW-1:0] WEIGHT_3_3 = W_3_3,
  parameter logic [DW-1:0] WEIGHT_3_4 = W_3_4,
  parameter logic [DW-1:0] WEIGHT_3_5 = W_3_5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] delta_1,
  input  logic signed [DW-1:0] delta_2,
  input  logic signed [DW-1:0] delta_3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] grad_1,
  output logic signed [DW-1:0] grad_2,
  output logic signed [DW-1:0] grad_3,
  output logic signed [DW-1:0] grad_4,
  output logic signed [DW-1:0] grad_5
);

  // Transposed table, input-major: entry i*3+j holds W[j][i].
  localparam logic [DW-1:0] W_TAB [NUM_IN*NUM_NODE] = '{
    WEIGHT_1_1, WEIGHT_2_1, WEIGHT_3_1,
    WEIGHT_1_2, WEIGHT_2_2, WEIGHT_3_2,
    WEIGHT_1_3, WEIGHT_2_3, WEIGHT_3_3,
    WEIGHT_1_4, WEIGHT_2_4, WEIGHT_3_4,
    WEIGHT_1_5, WEIGHT_2_5, WEIGHT_3_5
  };

  state_t                state_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [2:0]            i_cnt_reg;
  logic [1:0]            j_cnt_reg;
  logic                  accept;
  logic                  mac_en;
  logic                  mac_last;
  logic [3:0]            w_idx;
  logic signed [DW-1:0]  w_sel;
  logic signed [DW-1:0]  d_sel;
  logic [DW-1:0]         mac_out;
  logic [DW-1:0]         delta_in [NUM_NODE];

  assign delta_in[0] = delta_1;
  assign delta_in[1] = delta_2;
  assign delta_in[2] = delta_3;

  assign accept   = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign mac_en   = (state_reg == CALC);
  assign mac_last = (j_cnt_reg == 2'd2);
  assign w_idx    = 4'(i_cnt_reg) * 4'd3 + 4'(j_cnt_reg);
  assign w_sel    = W_TAB[w_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NODE; gi++) begin : g_delta
      logic [DW-1:0] delta_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          delta_reg <= '0;
        else if (accept)
          delta_reg <= delta_in[gi];
      end
    end

    // Each gradient is written once, on the last node product of its column.
    for (gi = 0; gi < NUM_IN; gi++) begin : g_grad
      logic [DW-1:0] grad_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          grad_reg <= '0;
        else if (mac_en && mac_last && (i_cnt_reg == 3'(gi)))
          grad_reg <= mac_out;
      end
    end
  endgenerate

  always_comb begin
    d_sel = g_delta[0].delta_reg;
    case (j_cnt_reg)
      2'd1:    d_sel = g_delta[1].delta_reg;
      2'd2:    d_sel = g_delta[2].delta_reg;
      default: d_sel = g_delta[0].delta_reg;
    endcase
  end

  fxp_mul_acc_sat u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (mac_en),
    .last    (mac_last),
    .a       (w_sel),
    .b       (d_sel),
    .sum_sat (mac_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      i_cnt_reg     <= '0;
      j_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= CALC;
            in_ready_reg <= 1'b0;
            i_cnt_reg    <= '0;
            j_cnt_reg    <= '0;
          end
        end
        CALC: begin
          if (mac_last) begin
            j_cnt_reg <= '0;
            if (i_cnt_reg == 3'(NUM_IN - 1)) begin
              i_cnt_reg     <= '0;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              i_cnt_reg <= i_cnt_reg + 3'd1;
            end
          end else begin
            j_cnt_reg <= j_cnt_reg + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign grad_1    = g_grad[0].grad_reg;
  assign grad_2    = g_grad[1].grad_reg;
  assign grad_3    = g_grad[2].grad_reg;
  assign grad_4    = g_grad[3].grad_reg;
  assign grad_5    = g_grad[4].grad_reg;

endmodule

// File: tb/tb_layer2_backprop.sv
// Directed and random checks of layer2_backprop against an arithmetic
// dot-product model of the transposed weight matrix.
module tb_layer2_backprop;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] delta_1 = '0, delta_2 = '0, delta_3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] grad_1, grad_2, grad_3, grad_4, grad_5;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // wt[node][input] in Q4.16, straight from the layer's weight list
  logic [19:0] wt [3][5] = '{
    '{20'h04CCC, 20'hFCCCD, 20'h08000, 20'hF6667, 20'h06666},
    '{20'hF4CCD, 20'h09999, 20'hFE667, 20'h03333, 20'hF3334},
    '{20'h06666, 20'hF8000, 20'h0CCCC, 20'hF199A, 20'h0B333}
  };

  layer2_backprop dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .delta_1(delta_1), .delta_2(delta_2), .delta_3(delta_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .grad_1(grad_1), .grad_2(grad_2), .grad_3(grad_3), .grad_4(grad_4), .grad_5(grad_5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [19:0] v);
    return v[19] ? longint'(v) - 64'sd1048576 : longint'(v);
  endfunction

  function automatic logic [19:0] ref_grad(input int i, input logic [19:0] d1,
                                           input logic [19:0] d2, input logic [19:0] d3);
    longint s;
    logic [63:0] u;
    s = sx(wt[0][i]) * sx(d1) + sx(wt[1][i]) * sx(d2) + sx(wt[2][i]) * sx(d3);
    s = s >>> 16;
    if (s > 64'sd524287) s = 64'sd524287;
    if (s < -64'sd524288) s = -64'sd524288;
    u = s;
    return u[19:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] grad_of(input int i);
    case (i)
      0: return grad_1;
      1: return grad_2;
      2: return grad_3;
      3: return grad_4;
      default: return grad_5;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present deltas for one accept edge, scramble inputs afterwards, wait for out_valid.
  task automatic launch(input logic [19:0] d1, input logic [19:0] d2, input logic [19:0] d3,
                        output int lat);
    delta_1 = d1; delta_2 = d2; delta_3 = d3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    delta_1 = 20'($urandom); delta_2 = 20'($urandom); delta_3 = 20'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic check_grads(input string tag, input logic [19:0] d1,
                             input logic [19:0] d2, input logic [19:0] d3);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_grad%0d", tag, i + 1), 32'(grad_of(i)), 32'(ref_grad(i, d1, d2, d3)));
    $display("txn %s d=(%h,%h,%h) g=(%h,%h,%h,%h,%h)", tag, d1, d2, d3,
             grad_1, grad_2, grad_3, grad_4, grad_5);
  endtask

  initial begin
    int lat;
    int stamp, prev_stamp;
    logic [19:0] d1, d2, d3, n1, n2, n3;
    logic [19:0] held [5];

    // reset: in_valid asserted, nothing may be captured
    in_valid = 1'b1; delta_1 = 20'h10000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_grad1", 32'(grad_1), 32'd0);
    check("rst_grad5", 32'(grad_5), 32'd0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    check("post_rst_idle", 32'(in_ready), 32'd1);

    // unit delta on node 1 returns node-1 weight row
    launch(20'h10000, 20'h0, 20'h0, lat);
    check("t1_latency", 32'(lat), 32'd15);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_grad1", 32'(grad_1), 32'h04CCC);
    check("t1_grad2", 32'(grad_2), 32'hFCCCD);
    check("t1_grad3", 32'(grad_3), 32'h08000);
    check("t1_grad4", 32'(grad_4), 32'hF6667);
    check("t1_grad5", 32'(grad_5), 32'h06666);
    check_grads("t1", 20'h10000, 20'h0, 20'h0);
    step();
    check("t1_back_idle", 32'(in_ready), 32'd1);
    check("t1_ov_low", 32'(out_valid), 32'd0);

    // all-ones deltas: column sums with truncation
    launch(20'h10000, 20'h10000, 20'h10000, lat);
    check("t2_latency", 32'(lat), 32'd15);
    check("t2_grad1", 32'(grad_1), 32'hFFFFF);
    check("t2_grad2", 32'(grad_2), 32'hFE666);
    check_grads("t2", 20'h10000, 20'h10000, 20'h10000);
    step();

    // saturation in both directions, then hold under backpressure
    out_ready = 1'b0;
    launch(20'h7FFFF, 20'h80000, 20'h7FFFF, lat);
    check("t3_latency", 32'(lat), 32'd15);
    check("t3_grad3_sat", 32'(grad_3), 32'h7FFFF);
    check("t3_grad4_sat", 32'(grad_4), 32'h80000);
    check_grads("t3", 20'h7FFFF, 20'h80000, 20'h7FFFF);
    for (int i = 0; i < 5; i++) held[i] = grad_of(i);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      delta_1 = 20'($urandom); delta_2 = 20'($urandom); delta_3 = 20'($urandom);
      step();
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++)
        check($sformatf("bp%0d_hold%0d", c, i + 1), 32'(grad_of(i)), 32'(held[i]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_ov", 32'(out_valid), 32'd0);
    $display("txn backpressure released after 10 held cycles");

    // reset during CALC aborts the transaction
    delta_1 = 20'h20000; delta_2 = 20'h30000; delta_3 = 20'h10000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("mid_calc_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_grad1", 32'(grad_1), 32'd0);
    check("abort_grad2", 32'(grad_2), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    launch(20'h10000, 20'h0, 20'h0, lat);
    check("t5_latency", 32'(lat), 32'd15);
    check("t5_grad1", 32'(grad_1), 32'h04CCC);
    check("t5_grad4", 32'(grad_4), 32'hF6667);
    check_grads("t5", 20'h10000, 20'h0, 20'h0);
    step();

    // back-to-back random transactions, in_valid held high
    d1 = 20'($urandom); d2 = 20'($urandom); d3 = 20'($urandom);
    delta_1 = d1; delta_2 = d2; delta_3 = d3; in_valid = 1'b1;
    prev_stamp = 0;
    for (int n = 0; n < 20; n++) begin
      check($sformatf("bb%0d_ready", n), 32'(in_ready), 32'd1);
      step();
      stamp = cyc;
      n1 = (n % 3 == 0) ? 20'($urandom) : 20'($signed(20'($urandom_range(0, 32767))) - 20'sd16384);
      n2 = 20'($urandom); n3 = (n % 2 == 0) ? 20'($urandom_range(0, 131071)) : 20'($urandom);
      delta_1 = n1; delta_2 = n2; delta_3 = n3;
      lat = 0;
      while (!out_valid && lat < 40) begin
        step();
        lat++;
      end
      check($sformatf("bb%0d_latency", n), 32'(lat), 32'd15);
      check_grads($sformatf("bb%0d", n), d1, d2, d3);
      if (n > 0) check($sformatf("bb%0d_period", n), 32'(stamp - prev_stamp), 32'd17);
      prev_stamp = stamp;
      d1 = n1; d2 = n2; d3 = n3;
      step();
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
